// File: rtl/conv_pkg.sv
// Shared widths and accumulator type for the 3x3 convolution MAC core.
package conv_pkg;

  localparam int unsigned BITS        = 32;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned TAPS        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned ACC_W       = 2 * BITS + 4;

  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/mac_tree.sv
// Nine signed element-wise products summed at full precision; purely combinational.
module mac_tree
  import conv_pkg::*;
#(
  parameter int unsigned BITS        = conv_pkg::BITS,
  parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE
) (
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] shift_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] kernel_in,
  output logic signed [2*BITS+3:0]                sum
);

  localparam int unsigned N_TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned P_W    = 2 * BITS;
  localparam int unsigned S_W    = 2 * BITS + 4;

  logic signed [P_W-1:0] prod [N_TAPS];

  always_comb begin
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      prod[i] = P_W'($signed(shift_in[i*BITS +: BITS])) *
                P_W'($signed(kernel_in[i*BITS +: BITS]));
    end
  end

  // Four guard bits cover nine full-range products, so no partial sum overflows.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      sum = sum + S_W'(prod[i]);
    end
  end

endmodule

// File: rtl/multiplier.sv
// 3x3 convolution MAC with registered pixel output.
// Define MULTIPLIER_SATURATE_EN to clamp the sum instead of wrapping it.
module multiplier
  import conv_pkg::*;
#(
  parameter int unsigned BITS        = conv_pkg::BITS,
  parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    out_en,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] shift_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] kernel_in,
  output logic [BITS-1:0]                         pixel_out
);

  localparam int unsigned S_W = 2 * BITS + 4;

  logic signed [S_W-1:0] sum;
  logic        [BITS-1:0] result;

  mac_tree #(
    .BITS        (BITS),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_mac_tree (
    .shift_in  (shift_in),
    .kernel_in (kernel_in),
    .sum       (sum)
  );

`ifdef MULTIPLIER_SATURATE_EN
  localparam logic signed [S_W-1:0] SAT_MAX = {{(S_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [S_W-1:0] SAT_MIN = {{(S_W-BITS+1){1'b1}}, {(BITS-1){1'b0}}};

  always_comb begin
    result = sum[BITS-1:0];
    if (sum > SAT_MAX)      result = SAT_MAX[BITS-1:0];
    else if (sum < SAT_MIN) result = SAT_MIN[BITS-1:0];
  end
`else
  logic sum_hi_unused;

  assign sum_hi_unused = ^sum[S_W-1:BITS];

  always_comb begin
    result = sum[BITS-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out <= '0;
    end else if (out_en) begin
      pixel_out <= result;
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the convolution MAC core.
module tb_multiplier;

  localparam int unsigned BITS = 32;
  localparam int unsigned TAPS = 9;
  localparam int unsigned W    = TAPS * BITS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            out_en;
  logic [W-1:0]    shift_in;
  logic [W-1:0]    kernel_in;
  logic [BITS-1:0] pixel_out;

  int n_vec = 0;
  int n_err = 0;

  multiplier #(
    .BITS        (BITS),
    .KERNEL_SIZE (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_en    (out_en),
    .shift_in  (shift_in),
    .kernel_in (kernel_in),
    .pixel_out (pixel_out)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [BITS-1:0] exp);
    n_vec++;
    assert (pixel_out === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, pixel_out, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] fill(input logic [BITS-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < TAPS; i++) r[i*BITS +: BITS] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ramp(input int base);
    logic [W-1:0] r;
    for (int i = 0; i < TAPS; i++) r[i*BITS +: BITS] = BITS'(base + i);
    return r;
  endfunction

  function automatic logic [W-1:0] one_hot(input int idx, input logic [BITS-1:0] v);
    logic [W-1:0] r;
    r = '0;
    r[idx*BITS +: BITS] = v;
    return r;
  endfunction

`ifdef MULTIPLIER_SATURATE_EN
  localparam logic [BITS-1:0] E_POS_OVF = 32'h7FFF_FFFF;
  localparam logic [BITS-1:0] E_NEG_OVF = 32'h8000_0000;
  localparam logic [BITS-1:0] E_WRAP_HI = 32'h7FFF_FFFF;
  localparam logic [BITS-1:0] E_MINSQ   = 32'h7FFF_FFFF;
`else
  localparam logic [BITS-1:0] E_POS_OVF = 32'h0000_0000;
  localparam logic [BITS-1:0] E_NEG_OVF = 32'h0000_0000;
  localparam logic [BITS-1:0] E_WRAP_HI = 32'hFFFF_FFFE;
  localparam logic [BITS-1:0] E_MINSQ   = 32'h0000_0000;
`endif

  initial begin
    rst_n     = 1'b0;
    out_en    = 1'b0;
    shift_in  = '0;
    kernel_in = '0;
    #5;
    check("reset_async", 32'h0);
    // Edge during reset with enable high and nonzero result must not load.
    shift_in  = fill(32'd1);
    kernel_in = ramp(1);
    out_en    = 1'b1;
    tick();
    check("reset_hold", 32'h0);

    #5 rst_n = 1'b1;
    shift_in  = fill(32'd5);
    kernel_in = fill(32'd0);
    tick();
    check("zero_kernel", 32'h0);
    shift_in  = '0;
    kernel_in = '0;
    tick();
    check("all_zero", 32'h0);
    tick();
    check("all_zero_hold", 32'h0);

    shift_in  = fill(32'd1);
    kernel_in = ramp(1);
    tick();
    check("ones_x_1to9", 32'd45);

    out_en    = 1'b0;
    shift_in  = '0;
    kernel_in = '0;
    tick();
    check("en_low_hold1", 32'd45);
    tick();
    check("en_low_hold2", 32'd45);
    out_en = 1'b1;
    tick();
    check("en_back_zero", 32'h0);

    shift_in  = one_hot(4, 32'hFFFF_FFFE);
    kernel_in = one_hot(4, 32'd3);
    tick();
    check("neg2_x_3", 32'hFFFF_FFFA);

    // sum (i-4)*(i+1) for i=0..8 = 60
    shift_in  = ramp(-4);
    kernel_in = ramp(1);
    tick();
    check("mixed_sign", 32'd60);

    shift_in  = fill(32'h0001_0000);
    kernel_in = fill(32'h0001_0000);
    tick();
    check("pos_overflow", E_POS_OVF);

    kernel_in = fill(32'hFFFF_0000);
    tick();
    check("neg_overflow", E_NEG_OVF);

    shift_in  = one_hot(0, 32'd2);
    kernel_in = one_hot(0, 32'h7FFF_FFFF);
    tick();
    check("just_over_max", E_WRAP_HI);

    shift_in  = one_hot(8, 32'h8000_0000);
    kernel_in = one_hot(8, 32'h8000_0000);
    tick();
    check("min_squared", E_MINSQ);

    kernel_in = one_hot(8, 32'd1);
    tick();
    check("min_times_one", 32'h8000_0000);

    // Alternating enable: only enabled edges load.
    shift_in  = fill(32'd1);
    kernel_in = ramp(1);
    out_en    = 1'b0;
    tick();
    check("toggle_off", 32'h8000_0000);
    out_en = 1'b1;
    tick();
    check("toggle_on", 32'd45);
    out_en   = 1'b0;
    shift_in = fill(32'd2);
    tick();
    check("toggle_off2", 32'd45);
    out_en = 1'b1;
    tick();
    check("toggle_on2", 32'd90);

    // Async reset between edges while holding a nonzero value.
    shift_in = fill(32'd1);
    tick();
    check("preload_45", 32'd45);
    #10 rst_n = 1'b0;
    #1;
    check("mid_cycle_reset", 32'h0);
    #5 rst_n = 1'b1;
    tick();
    check("post_reset_load", 32'd45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
